// File: rtl/control_acceso_parqueo.sv
// Parking-entrance access controller: PIN-gated barrier with wrong-PIN and
// tailgating alarms. All outputs registered, one-cycle response latency.
module control_acceso_parqueo #(
  parameter logic [15:0]  CLAVE_CORRECTA = 16'h3257,
  parameter int unsigned  MAX_INTENTOS   = 3,
  parameter int unsigned  CNT_W          = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sensor_llegada_vehiculo,
  input  logic             sensor_ingreso_vehiculo,
  input  logic [15:0]      clave_ingresada,
  input  logic             clave_valida,
  output logic             senal_compuerta,
  output logic             senal_alarma_pin,
  output logic             senal_alarma_bloqueo,
  output logic [CNT_W-1:0] cuenta_intentos
);

  typedef enum logic [2:0] {
    IDLE,
    ESPERA_CLAVE,
    ABIERTA,
    PASO,
    BLOQUEO
  } estado_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  estado_t          estado_q, estado_d;
  logic [CNT_W-1:0] cuenta_d;
  logic [CNT_W-1:0] cuenta_inc;
  logic             alarma_pin_d;
  logic             clave_ok;

  assign clave_ok   = (clave_ingresada == CLAVE_CORRECTA);
  assign cuenta_inc = (cuenta_intentos == CNT_MAX) ? cuenta_intentos
                                                   : cuenta_intentos + CNT_W'(1);

  // Next-state, counter and PIN-alarm logic
  always_comb begin
    estado_d     = estado_q;
    cuenta_d     = cuenta_intentos;
    alarma_pin_d = senal_alarma_pin;

    unique case (estado_q)
      IDLE: begin
        if (sensor_ingreso_vehiculo)
          estado_d = BLOQUEO;
        else if (sensor_llegada_vehiculo)
          estado_d = ESPERA_CLAVE;
      end

      ESPERA_CLAVE: begin
        // Tailgating wins over a simultaneous strobe, which is discarded
        if (sensor_ingreso_vehiculo) begin
          estado_d = BLOQUEO;
        end else if (clave_valida) begin
          if (clave_ok) begin
            estado_d     = ABIERTA;
            cuenta_d     = '0;
            alarma_pin_d = 1'b0;
          end else begin
            cuenta_d = cuenta_inc;
            if (32'(cuenta_inc) >= MAX_INTENTOS)
              alarma_pin_d = 1'b1;
          end
        end else if (!sensor_llegada_vehiculo) begin
          estado_d = IDLE;
        end
      end

      ABIERTA: begin
        if (sensor_ingreso_vehiculo)
          estado_d = PASO;
      end

      PASO: begin
        if (!sensor_ingreso_vehiculo)
          estado_d = IDLE;
      end

      BLOQUEO: begin
        if (clave_valida) begin
          if (clave_ok) begin
            estado_d     = ABIERTA;
            cuenta_d     = '0;
            alarma_pin_d = 1'b0;
          end else begin
            cuenta_d = cuenta_inc;
            if (32'(cuenta_inc) >= MAX_INTENTOS)
              alarma_pin_d = 1'b1;
          end
        end
      end

      default: estado_d = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q             <= IDLE;
      cuenta_intentos      <= '0;
      senal_alarma_pin     <= 1'b0;
      senal_compuerta      <= 1'b0;
      senal_alarma_bloqueo <= 1'b0;
    end else begin
      estado_q             <= estado_d;
      cuenta_intentos      <= cuenta_d;
      senal_alarma_pin     <= alarma_pin_d;
      senal_compuerta      <= (estado_d == ABIERTA) || (estado_d == PASO);
      senal_alarma_bloqueo <= (estado_d == BLOQUEO);
    end
  end

endmodule
